otter_cu_fsm: RTL and testbench

- Multicycle control FSM for the OTTER RV32I core.
- Sequences each instruction through fetch, execute, optional load writeback, and interrupt entry.
- Per state, it drives the write enables, the memory read/write strobes and the ALU operand-B select code, which feeds the srcB mux select (alu_srcB).
- Sits beside the decoder; consumes opcode/func3 from the instruction register plus the external interrupt line.

---
 rtl/otter_ctrl_pkg.sv | 36 +++
 rtl/otter_exec_decode.sv | 81 ++++++++
 rtl/otter_cu_fsm.sv | 127 ++++++++++++
 tb/tb_otter_cu_fsm.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_ctrl_pkg.sv
// Shared definitions for the OTTER multicycle control unit: FSM states,
// RV32I opcodes, operand-B select codes and SYSTEM func3 values.
package otter_ctrl_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      WB    = 2'd2,
      INTR  = 2'd3
   } state_t;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_LUI    = 7'b0110111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_SYSTEM = 7'b1110011
   } opcode_t;

   localparam logic [2:0] SRCB_RS2 = 3'd0;
   localparam logic [2:0] SRCB_I   = 3'd1;
   localparam logic [2:0] SRCB_S   = 3'd2;
   localparam logic [2:0] SRCB_PC  = 3'd3;
   localparam logic [2:0] SRCB_CSR = 3'd4;

   localparam logic [2:0] F3_MRET  = 3'b000;
   localparam logic [2:0] F3_CSRRW = 3'b001;
   localparam logic [2:0] F3_CSRRS = 3'b010;
   localparam logic [2:0] F3_CSRRC = 3'b011;

endpackage

// File: rtl/otter_exec_decode.sv
// Combinational decode of the EXEC-state control word from opcode/func3.
// The FSM gates every output here with state==EXEC.
module otter_exec_decode
   import otter_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   output logic       pc_we,
   output logic       rf_we,
   output logic       mem_rden2,
   output logic       mem_we2,
   output logic       csr_we,
   output logic       mret_exec,
   output logic       illegal_op,
   output logic       is_load,
   output logic [2:0] alu_srcb
);

   // Opcode/func3 to enables; unknown encodings become a PC+4 NOP flagged illegal.
   always_comb begin
      pc_we      = 1'b0;
      rf_we      = 1'b0;
      mem_rden2  = 1'b0;
      mem_we2    = 1'b0;
      csr_we     = 1'b0;
      mret_exec  = 1'b0;
      illegal_op = 1'b0;
      is_load    = 1'b0;
      alu_srcb   = SRCB_RS2;
      case (opcode)
         OPC_LOAD: begin
            mem_rden2 = 1'b1;
            is_load   = 1'b1;
            alu_srcb  = SRCB_I;
         end
         OPC_STORE: begin
            mem_we2  = 1'b1;
            pc_we    = 1'b1;
            alu_srcb = SRCB_S;
         end
         OPC_OP: begin
            rf_we = 1'b1;
            pc_we = 1'b1;
         end
         OPC_OP_IMM: begin
            rf_we    = 1'b1;
            pc_we    = 1'b1;
            alu_srcb = SRCB_I;
         end
         OPC_AUIPC: begin
            rf_we    = 1'b1;
            pc_we    = 1'b1;
            alu_srcb = SRCB_PC;
         end
         OPC_LUI, OPC_JAL, OPC_JALR: begin
            rf_we = 1'b1;
            pc_we = 1'b1;
         end
         OPC_BRANCH: begin
            pc_we = 1'b1;
         end
         OPC_SYSTEM: begin
            pc_we = 1'b1;
            case (func3)
               F3_MRET: mret_exec = 1'b1;
               F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
                  rf_we    = 1'b1;
                  csr_we   = 1'b1;
                  alu_srcb = SRCB_CSR;
               end
               default: illegal_op = 1'b1;
            endcase
         end
         default: begin
            pc_we      = 1'b1;
            illegal_op = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/otter_cu_fsm.sv
// Multicycle control FSM for the OTTER RV32I core: FETCH -> EXEC -> (WB) ->
// optional INTR entry at instruction boundaries. Outputs are combinational.
module otter_cu_fsm
   import otter_ctrl_pkg::*;
#(
   parameter bit INTR_SET_WINS = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic       intr,
   input  logic       mie,
   output logic       PC_WE,
   output logic       RF_WE,
   output logic       memRDEN1,
   output logic       memRDEN2,
   output logic       memWE2,
   output logic       csr_WE,
   output logic       int_taken,
   output logic       mret_exec,
   output logic [2:0] alu_srcB,
   output logic       illegal_op,
   output logic       instr_retired
);

   state_t     state_reg, state_next;
   logic       intr_pend_reg, intr_pend_next;
   logic       take_intr;

   logic       dec_pc_we, dec_rf_we, dec_rden2, dec_we2, dec_csr_we;
   logic       dec_mret, dec_illegal, dec_is_load;
   logic [2:0] dec_srcb;

   otter_exec_decode u_exec_decode (
      .opcode     (opcode),
      .func3      (func3),
      .pc_we      (dec_pc_we),
      .rf_we      (dec_rf_we),
      .mem_rden2  (dec_rden2),
      .mem_we2    (dec_we2),
      .csr_we     (dec_csr_we),
      .mret_exec  (dec_mret),
      .illegal_op (dec_illegal),
      .is_load    (dec_is_load),
      .alu_srcb   (dec_srcb)
   );

   // A live request line counts at the boundary even before it lands in intr_pend.
   assign take_intr = (intr_pend_reg | intr) & mie;

   // State and pending-interrupt registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg     <= FETCH;
         intr_pend_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         intr_pend_reg <= intr_pend_next;
      end
   end

   // Pending flag: set by intr, cleared on entry; the tie goes to INTR_SET_WINS.
   always_comb begin
      intr_pend_next = intr_pend_reg;
      if (intr && state_reg == INTR)
         intr_pend_next = INTR_SET_WINS;
      else if (intr)
         intr_pend_next = 1'b1;
      else if (state_reg == INTR)
         intr_pend_next = 1'b0;
   end

   // Next state and per-state control outputs; everything held low during reset.
   always_comb begin
      state_next    = state_reg;
      PC_WE         = 1'b0;
      RF_WE         = 1'b0;
      memRDEN1      = 1'b0;
      memRDEN2      = 1'b0;
      memWE2        = 1'b0;
      csr_WE        = 1'b0;
      int_taken     = 1'b0;
      mret_exec     = 1'b0;
      alu_srcB      = SRCB_RS2;
      illegal_op    = 1'b0;
      instr_retired = 1'b0;
      if (!RST) begin
         case (state_reg)
            FETCH: begin
               memRDEN1   = 1'b1;
               state_next = EXEC;
            end
            EXEC: begin
               PC_WE         = dec_pc_we;
               RF_WE         = dec_rf_we;
               memRDEN2      = dec_rden2;
               memWE2        = dec_we2;
               csr_WE        = dec_csr_we;
               mret_exec     = dec_mret;
               alu_srcB      = dec_srcb;
               illegal_op    = dec_illegal;
               instr_retired = !dec_is_load;
               if (dec_is_load)
                  state_next = WB;
               else if (take_intr)
                  state_next = INTR;
               else
                  state_next = FETCH;
            end
            WB: begin
               RF_WE         = 1'b1;
               PC_WE         = 1'b1;
               instr_retired = 1'b1;
               state_next    = take_intr ? INTR : FETCH;
            end
            INTR: begin
               int_taken  = 1'b1;
               PC_WE      = 1'b1;
               state_next = FETCH;
            end
            default: state_next = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Self-checking bench for otter_cu_fsm: a directed per-cycle vector table
// followed by randomized instruction streams checked against a queue model.
module tb_otter_cu_fsm;

   logic       CLK = 1'b0;
   logic       RST;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic       intr;
   logic       mie;
   logic       PC_WE, RF_WE, memRDEN1, memRDEN2, memWE2, csr_WE;
   logic       int_taken, mret_exec, illegal_op, instr_retired;
   logic [2:0] alu_srcB;

   int n_checks = 0;
   int n_fail   = 0;

   otter_cu_fsm #(.INTR_SET_WINS(1'b1)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .opcode        (opcode),
      .func3         (func3),
      .intr          (intr),
      .mie           (mie),
      .PC_WE         (PC_WE),
      .RF_WE         (RF_WE),
      .memRDEN1      (memRDEN1),
      .memRDEN2      (memRDEN2),
      .memWE2        (memWE2),
      .csr_WE        (csr_WE),
      .int_taken     (int_taken),
      .mret_exec     (mret_exec),
      .alu_srcB      (alu_srcB),
      .illegal_op    (illegal_op),
      .instr_retired (instr_retired)
   );

   always #5 CLK = ~CLK;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_ADD = 7'b0110011;
   localparam logic [6:0] OP_SYS = 7'b1110011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   // Control word layout:
   // {PC_WE,RF_WE,RDEN1,RDEN2,WE2,csr_WE,int_taken,mret,srcB[2:0],illegal,retired}
   function automatic logic [12:0] cw(input bit pc, rf, r1, r2, we2, csr, it, mr,
                                      input int sb, input bit ill, ret);
      logic [2:0] s;
      s = sb[2:0];
      return {pc, rf, r1, r2, we2, csr, it, mr, s, ill, ret};
   endfunction

   // Expected EXEC-cycle control word, straight from the opcode table.
   function automatic logic [12:0] exec_cw(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         7'b0000011: return cw(0,0,0,1,0,0,0,0,1,0,0);
         7'b0100011: return cw(1,0,0,0,1,0,0,0,2,0,1);
         7'b0110011: return cw(1,1,0,0,0,0,0,0,0,0,1);
         7'b0010011: return cw(1,1,0,0,0,0,0,0,1,0,1);
         7'b0010111: return cw(1,1,0,0,0,0,0,0,3,0,1);
         7'b0110111, 7'b1101111, 7'b1100111: return cw(1,1,0,0,0,0,0,0,0,0,1);
         7'b1100011: return cw(1,0,0,0,0,0,0,0,0,0,1);
         7'b1110011: begin
            if (f3 == 3'b000) return cw(1,0,0,0,0,0,0,1,0,0,1);
            if (f3 >= 3'b001 && f3 <= 3'b011) return cw(1,1,0,0,0,1,0,0,4,0,1);
            return cw(1,0,0,0,0,0,0,0,0,1,1);
         end
         default: return cw(1,0,0,0,0,0,0,0,0,1,1);
      endcase
   endfunction

   function automatic logic [12:0] actual_cw();
      return {PC_WE, RF_WE, memRDEN1, memRDEN2, memWE2, csr_WE, int_taken,
              mret_exec, alu_srcB, illegal_op, instr_retired};
   endfunction

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        rst;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        irq;
      logic        ie;
      logic [12:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic rst, input logic [6:0] op,
                      input logic [2:0] f3, input logic irq, input logic ie,
                      input logic [12:0] exp);
      vec_t v;
      v.name = name; v.rst = rst; v.op = op; v.f3 = f3;
      v.irq = irq; v.ie = ie; v.exp = exp;
      vecs.push_back(v);
   endtask

   logic [12:0] Z, F, ADD_E, LW_E, LW_W, IN;

   initial begin
      logic [12:0] e;
      byte         plan[$];
      byte         kind;
      bit          pend;
      bit          take;
      bit          boundary;
      logic [6:0]  cur_op;
      logic [2:0]  cur_f3;
      logic [6:0]  op_list[10];
      int          retired_cnt;

      RST = 1'b1; opcode = '0; func3 = '0; intr = 1'b0; mie = 1'b0;

      Z     = '0;
      F     = cw(0,0,1,0,0,0,0,0,0,0,0);
      ADD_E = cw(1,1,0,0,0,0,0,0,0,0,1);
      LW_E  = cw(0,0,0,1,0,0,0,0,1,0,0);
      LW_W  = cw(1,1,0,0,0,0,0,0,0,0,1);
      IN    = cw(1,0,0,0,0,0,1,0,0,0,0);

      // ---------------- directed vector table (one row per cycle) ----------------
      add("rst0",        1, OP_ADD, 0, 0, 0, Z);
      add("rst1",        1, OP_ADD, 0, 1, 1, Z);
      add("add_fetch",   0, OP_ADD, 0, 0, 0, F);
      add("add_exec",    0, OP_ADD, 0, 0, 0, ADD_E);
      add("lw_fetch",    0, OP_LW,  0, 0, 0, F);
      add("lw_exec",     0, OP_LW,  0, 0, 0, LW_E);
      add("lw_wb",       0, OP_LW,  0, 0, 0, LW_W);
      add("sw_fetch",    0, OP_SW,  0, 0, 0, F);
      add("sw_exec",     0, OP_SW,  0, 0, 0, cw(1,0,0,0,1,0,0,0,2,0,1));
      add("csrrs_fetch", 0, OP_SYS, 3'b010, 0, 0, F);
      add("csrrs_exec",  0, OP_SYS, 3'b010, 0, 0, cw(1,1,0,0,0,1,0,0,4,0,1));
      // intr pulse in FETCH, mie=1: taken after EXEC
      add("irq_fetch",   0, OP_ADD, 0, 1, 1, F);
      add("irq_exec",    0, OP_ADD, 0, 0, 1, ADD_E);
      add("irq_entry",   0, OP_ADD, 0, 0, 1, IN);
      add("post_fetch",  0, OP_ADD, 0, 0, 1, F);
      add("post_exec",   0, OP_ADD, 0, 0, 1, ADD_E);
      add("pend_clear",  0, OP_ADD, 0, 0, 1, F);
      add("pend_exec",   0, OP_ADD, 0, 0, 1, ADD_E);
      // intr with mie=0: held until a boundary with mie=1
      add("m0_fetch",    0, OP_ADD, 0, 1, 0, F);
      add("m0_exec",     0, OP_ADD, 0, 0, 0, ADD_E);
      add("m0_fetch2",   0, OP_ADD, 0, 0, 0, F);
      add("m0_exec2",    0, OP_ADD, 0, 0, 0, ADD_E);
      add("m1_fetch",    0, OP_ADD, 0, 0, 1, F);
      add("m1_exec",     0, OP_ADD, 0, 0, 1, ADD_E);
      add("m1_entry",    0, OP_ADD, 0, 0, 1, IN);
      // LW with intr in EXEC: WB completes before entry
      add("lwi_fetch",   0, OP_LW,  0, 0, 1, F);
      add("lwi_exec",    0, OP_LW,  0, 1, 1, LW_E);
      add("lwi_wb",      0, OP_LW,  0, 0, 1, LW_W);
      add("lwi_entry",   0, OP_LW,  0, 0, 1, IN);
      add("lwi_once",    0, OP_ADD, 0, 0, 1, F);
      add("lwi_exec2",   0, OP_ADD, 0, 0, 1, ADD_E);
      // mret with a live request: mie of that EXEC cycle decides
      add("mret_fetch",  0, OP_SYS, 3'b000, 0, 1, F);
      add("mret_exec",   0, OP_SYS, 3'b000, 1, 1, cw(1,0,0,0,0,0,0,1,0,0,1));
      add("mret_entry",  0, OP_SYS, 3'b000, 0, 1, IN);
      // illegal encodings
      add("bad_fetch",   0, OP_BAD, 0, 0, 0, F);
      add("bad_exec",    0, OP_BAD, 0, 0, 0, cw(1,0,0,0,0,0,0,0,0,1,1));
      add("sys4_fetch",  0, OP_SYS, 3'b100, 0, 0, F);
      add("sys4_exec",   0, OP_SYS, 3'b100, 0, 0, cw(1,0,0,0,0,0,0,0,0,1,1));
      // reset during load writeback
      add("rlw_fetch",   0, OP_LW,  0, 0, 0, F);
      add("rlw_exec",    0, OP_LW,  0, 0, 0, LW_E);
      add("rlw_wb_rst",  1, OP_LW,  0, 0, 0, Z);
      add("rlw_refetch", 0, OP_ADD, 0, 0, 0, F);
      add("rlw_exec2",   0, OP_ADD, 0, 0, 0, ADD_E);

      foreach (vecs[i]) begin
         @(posedge CLK); #1;
         RST = vecs[i].rst; opcode = vecs[i].op; func3 = vecs[i].f3;
         intr = vecs[i].irq; mie = vecs[i].ie;
         @(negedge CLK);
         check(vecs[i].name, actual_cw(), vecs[i].exp);
         $display("vec %0d %s: outputs %b", i, vecs[i].name, actual_cw());
      end

      // ---------------- randomized stream vs. queue model ----------------
      op_list = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0010111,
                  7'b0110111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b1110011};
      plan.delete();
      pend = 1'b0;
      cur_op = OP_ADD; cur_f3 = '0;
      retired_cnt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge CLK); #1;
         if (plan.size() == 0) begin
            if ($urandom_range(0, 9) == 0) cur_op = 7'($urandom);
            else cur_op = op_list[$urandom_range(0, 9)];
            cur_f3 = 3'($urandom);
            plan.push_back("F");
            plan.push_back("E");
            if (cur_op == OP_LW) plan.push_back("W");
         end
         RST    = (cyc == 0) || ($urandom_range(0, 99) == 0);
         opcode = cur_op;
         func3  = cur_f3;
         intr   = ($urandom_range(0, 7) == 0);
         mie    = ($urandom_range(0, 3) != 0);
         @(negedge CLK);
         kind = plan[0];
         if (RST) e = Z;
         else if (kind == "F") e = F;
         else if (kind == "E") e = exec_cw(cur_op, cur_f3);
         else if (kind == "W") e = LW_W;
         else e = IN;
         check($sformatf("rand_c%0d_%c", cyc, kind), actual_cw(), e);
         if (!RST && e[0]) begin
            retired_cnt++;
            $display("rand cyc %0d: op %b f3 %b retired", cyc, cur_op, cur_f3);
         end
         if (RST) begin
            plan.delete();
            pend = 1'b0;
         end else begin
            void'(plan.pop_front());
            boundary = (kind == "E" && cur_op != OP_LW) || kind == "W";
            take = (pend | intr) & mie;
            if (boundary && take) plan.push_front("I");
            if (intr) pend = 1'b1;
            else if (kind == "I") pend = 1'b0;
         end
      end
      $display("random phase: %0d instructions retired", retired_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
